// File: rtl/cc_speedcounter.sv
// rtl/cc_speedcounter.sv - period counter restarted by the speed comparator, with tick pulse and tick count
// Optional watchdog wrap on an all-ones count is built when CC_SPEEDCOUNTER_WATCHDOG_EN is defined.
`timescale 1ns/1ps
module cc_speedcounter #(
  parameter int SPEEDCOUNTER_DATAWIDTH = 28,
  parameter int SPEEDCOUNTER_TICKWIDTH = 8
) (
  input  logic                              CC_SPEEDCOUNTER_CLOCK_50,
  input  logic                              CC_SPEEDCOUNTER_RESET_InLow,
  input  logic                              CC_SPEEDCOUNTER_start_InLow,
  input  logic                              CC_SPEEDCOUNTER_pause_InLow,
  input  logic                              CC_SPEEDCOUNTER_clear_InLow,
  output logic [SPEEDCOUNTER_DATAWIDTH-1:0] CC_SPEEDCOUNTER_data_OutBUS,
  output logic                              CC_SPEEDCOUNTER_tick_Out,
  output logic [SPEEDCOUNTER_TICKWIDTH-1:0] CC_SPEEDCOUNTER_tickCount_OutBUS,
  output logic                              CC_SPEEDCOUNTER_running_Out,
  output logic                              CC_SPEEDCOUNTER_timeout_Out
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} stateType;

  localparam logic [SPEEDCOUNTER_DATAWIDTH-1:0] countMax = '1;
  localparam logic [SPEEDCOUNTER_DATAWIDTH-1:0] countOne = 1;
  localparam logic [SPEEDCOUNTER_TICKWIDTH-1:0] tickOne  = 1;

  stateType state;

`ifdef CC_SPEEDCOUNTER_WATCHDOG_EN
  logic timeoutFlag;
  assign CC_SPEEDCOUNTER_timeout_Out = timeoutFlag;
`else
  assign CC_SPEEDCOUNTER_timeout_Out = 1'b0;
`endif

  always_ff @(posedge CC_SPEEDCOUNTER_CLOCK_50 or negedge CC_SPEEDCOUNTER_RESET_InLow) begin
    if (!CC_SPEEDCOUNTER_RESET_InLow) begin
      state                            <= IDLE;
      CC_SPEEDCOUNTER_data_OutBUS      <= '0;
      CC_SPEEDCOUNTER_tick_Out         <= 1'b0;
      CC_SPEEDCOUNTER_tickCount_OutBUS <= '0;
      CC_SPEEDCOUNTER_running_Out      <= 1'b0;
`ifdef CC_SPEEDCOUNTER_WATCHDOG_EN
      timeoutFlag                      <= 1'b0;
`endif
    end else if (!CC_SPEEDCOUNTER_start_InLow) begin
      // Start wins over everything else in every state and never produces a tick.
      state                            <= RUN;
      CC_SPEEDCOUNTER_data_OutBUS      <= '0;
      CC_SPEEDCOUNTER_tick_Out         <= 1'b0;
      CC_SPEEDCOUNTER_tickCount_OutBUS <= '0;
      CC_SPEEDCOUNTER_running_Out      <= 1'b1;
`ifdef CC_SPEEDCOUNTER_WATCHDOG_EN
      timeoutFlag                      <= 1'b0;
`endif
    end else begin
      CC_SPEEDCOUNTER_tick_Out <= 1'b0;
      case (state)
        IDLE: begin
          CC_SPEEDCOUNTER_data_OutBUS <= '0;
          CC_SPEEDCOUNTER_running_Out <= 1'b0;
        end
        RUN: begin
          if (!CC_SPEEDCOUNTER_clear_InLow) begin
            CC_SPEEDCOUNTER_data_OutBUS      <= '0;
            CC_SPEEDCOUNTER_tick_Out         <= 1'b1;
            CC_SPEEDCOUNTER_tickCount_OutBUS <= CC_SPEEDCOUNTER_tickCount_OutBUS + tickOne;
          end else if (!CC_SPEEDCOUNTER_pause_InLow) begin
            CC_SPEEDCOUNTER_data_OutBUS <= CC_SPEEDCOUNTER_data_OutBUS;
          end else if (CC_SPEEDCOUNTER_data_OutBUS == countMax) begin
`ifdef CC_SPEEDCOUNTER_WATCHDOG_EN
            // Comparator never fired over a full count range: wrap and flag it.
            CC_SPEEDCOUNTER_data_OutBUS <= '0;
            timeoutFlag                 <= 1'b1;
`else
            CC_SPEEDCOUNTER_data_OutBUS <= countMax;
`endif
          end else begin
            CC_SPEEDCOUNTER_data_OutBUS <= CC_SPEEDCOUNTER_data_OutBUS + countOne;
          end
          // A simultaneous clear still lets the pause request take the FSM out of RUN.
          if (!CC_SPEEDCOUNTER_pause_InLow) begin
            state                       <= PAUSE;
            CC_SPEEDCOUNTER_running_Out <= 1'b0;
          end
        end
        PAUSE: begin
          if (CC_SPEEDCOUNTER_pause_InLow) begin
            state                       <= RUN;
            CC_SPEEDCOUNTER_running_Out <= 1'b1;
          end
        end
        default: begin
          state                       <= IDLE;
          CC_SPEEDCOUNTER_running_Out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cc_speedcounter.sv
// tb/tb_cc_speedcounter.sv - self-checking bench for cc_speedcounter with a behavioural comparator
`timescale 1ns/1ps
module tb_cc_speedcounter;

  localparam int DW = 4;
  localparam int TW = 8;
`ifdef CC_SPEEDCOUNTER_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          startN = 1'b1;
  logic          pauseN = 1'b1;
  logic          clearN;
  logic          holdHigh = 1'b0;
  logic [DW-1:0] limit = 4'd5;
  logic [DW-1:0] data;
  logic          tick;
  logic [TW-1:0] tickCount;
  logic          running;
  logic          timeout;

  always #5 clk = ~clk;

  // Comparator: low whenever count >= limit, unless forced inactive.
  assign clearN = holdHigh | (data < limit);

  cc_speedcounter #(
    .SPEEDCOUNTER_DATAWIDTH(DW),
    .SPEEDCOUNTER_TICKWIDTH(TW)
  ) dut (
    .CC_SPEEDCOUNTER_CLOCK_50        (clk),
    .CC_SPEEDCOUNTER_RESET_InLow     (rstN),
    .CC_SPEEDCOUNTER_start_InLow     (startN),
    .CC_SPEEDCOUNTER_pause_InLow     (pauseN),
    .CC_SPEEDCOUNTER_clear_InLow     (clearN),
    .CC_SPEEDCOUNTER_data_OutBUS     (data),
    .CC_SPEEDCOUNTER_tick_Out        (tick),
    .CC_SPEEDCOUNTER_tickCount_OutBUS(tickCount),
    .CC_SPEEDCOUNTER_running_Out     (running),
    .CC_SPEEDCOUNTER_timeout_Out     (timeout)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          tick;
    logic [TW-1:0] tc;
    logic          run;
    logic          tmo;
  } outT;

  typedef struct packed {
    logic startN;
    logic pauseN;
    outT  exp;
  } vecT;

  vecT table_q[$];
  outT expQ[$];
  int  vectors = 0;
  int  miscompares = 0;

  function automatic outT mk(input int d, input bit t, input int tc, input bit r, input bit tmo);
    outT o;
    o.data = d[DW-1:0];
    o.tick = t;
    o.tc   = tc[TW-1:0];
    o.run  = r;
    o.tmo  = tmo;
    return o;
  endfunction

  function automatic void addVec(input logic s, input logic p, input outT e);
    vecT v;
    v.startN = s;
    v.pauseN = p;
    v.exp    = e;
    table_q.push_back(v);
  endfunction

  task automatic check(input string name);
    outT act;
    outT exp;
    exp = expQ.pop_front();
    act = {data, tick, tickCount, running, timeout};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got data=%0d tick=%0b tc=%0d run=%0b tmo=%0b, want data=%0d tick=%0b tc=%0d run=%0b tmo=%0b",
               name, act.data, act.tick, act.tc, act.run, act.tmo,
               exp.data, exp.tick, exp.tc, exp.run, exp.tmo);
    end
  endtask

  task automatic step(input logic s, input logic p, input outT e, input string name);
    @(negedge clk);
    startN = s;
    pauseN = p;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    check(name);
  endtask

  initial begin
    int tcExp;
    int d;

    // Reset state, held through a couple of edges.
    #12;
    expQ.push_back(mk(0, 0, 0, 0, 0));
    check("reset");
    @(negedge clk);
    rstN = 1'b1;
    step(1'b1, 1'b1, mk(0, 0, 0, 0, 0), "idle_no_start");

    // Limit 5: period of 6, pause at 3, restart at 4 with tickCount 7, clear+pause together.
    addVec(1'b0, 1'b1, mk(0, 0, 0, 1, 0));
    for (int p = 1; p <= 6; p++) begin
      for (int i = 1; i <= 5; i++) addVec(1'b1, 1'b1, mk(i, 0, p - 1, 1, 0));
      addVec(1'b1, 1'b1, mk(0, 1, p, 1, 0));
    end
    for (int i = 1; i <= 3; i++) addVec(1'b1, 1'b1, mk(i, 0, 6, 1, 0));
    repeat (4) addVec(1'b1, 1'b0, mk(3, 0, 6, 0, 0));
    addVec(1'b1, 1'b1, mk(3, 0, 6, 1, 0));
    addVec(1'b1, 1'b1, mk(4, 0, 6, 1, 0));
    addVec(1'b1, 1'b1, mk(5, 0, 6, 1, 0));
    addVec(1'b1, 1'b1, mk(0, 1, 7, 1, 0));
    for (int i = 1; i <= 4; i++) addVec(1'b1, 1'b1, mk(i, 0, 7, 1, 0));
    addVec(1'b0, 1'b1, mk(0, 0, 0, 1, 0));
    for (int i = 1; i <= 5; i++) addVec(1'b1, 1'b1, mk(i, 0, 0, 1, 0));
    addVec(1'b1, 1'b0, mk(0, 1, 1, 0, 0));
    addVec(1'b1, 1'b0, mk(0, 0, 1, 0, 0));
    addVec(1'b1, 1'b1, mk(0, 0, 1, 1, 0));
    addVec(1'b1, 1'b1, mk(1, 0, 1, 1, 0));

    for (int i = 0; i < table_q.size(); i++)
      step(table_q[i].startN, table_q[i].pauseN, table_q[i].exp, $sformatf("vec%0d", i));

    // Limit dropped to 0 below the current count: tick every cycle, tickCount wraps.
    limit = '0;
    tcExp = 1;
    for (int i = 0; i < 300; i++) begin
      tcExp = (tcExp + 1) % 256;
      step(1'b1, 1'b1, mk(0, 1, tcExp, 1, 0), $sformatf("lim0_%0d", i));
    end

    // Comparator never fires: saturate, or watchdog wrap with sticky timeout.
    holdHigh = 1'b1;
    step(1'b0, 1'b1, mk(0, 0, 0, 1, 0), "sat_start");
    for (int i = 1; i <= 20; i++) begin
      d = WD ? (i % 16) : ((i > 15) ? 15 : i);
      step(1'b1, 1'b1, mk(d, 0, 0, 1, WD && (i >= 16)), $sformatf("sat_%0d", i));
    end
    step(1'b0, 1'b1, mk(0, 0, 0, 1, 0), "sat_restart");
    holdHigh = 1'b0;

    // Asynchronous reset mid-count at data 9.
    limit = 4'd10;
    for (int i = 1; i <= 9; i++) step(1'b1, 1'b1, mk(i, 0, 0, 1, 0), $sformatf("pre_rst_%0d", i));
    #2;
    rstN = 1'b0;
    #1;
    expQ.push_back(mk(0, 0, 0, 0, 0));
    check("async_reset");
    @(negedge clk);
    rstN = 1'b1;
    step(1'b1, 1'b1, mk(0, 0, 0, 0, 0), "idle_after_rst_a");
    step(1'b1, 1'b1, mk(0, 0, 0, 0, 0), "idle_after_rst_b");
    step(1'b0, 1'b1, mk(0, 0, 0, 1, 0), "start_after_rst");
    step(1'b1, 1'b1, mk(1, 0, 0, 1, 0), "first_inc_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cc_speedcounter.md
# cc_speedcounter

Free-running cycle counter that drives the data bus of the downstream speed comparator and restarts whenever that comparator reports the limit has been reached. The period between restarts therefore tracks the programmed limit. The block converts the comparator's active-low "limit reached" level into a one-cycle tick pulse and a running tick count for the game/speed logic. A small run/pause/restart state machine controls it.

## Interface
- SPEEDCOUNTER_DATAWIDTH, 28: width of the count bus; must match the comparator's data width.
- SPEEDCOUNTER_TICKWIDTH, 8: width of the tick counter.
- CC_SPEEDCOUNTER_CLOCK_50  in  1  system clock; all state changes on the rising edge.
- CC_SPEEDCOUNTER_RESET_InLow  in  1  reset, asynchronous, active-low.
- CC_SPEEDCOUNTER_start_InLow  in  1  synchronous restart/start request, active-low level.
- CC_SPEEDCOUNTER_pause_InLow  in  1  hold request, active-low level.
- CC_SPEEDCOUNTER_clear_InLow  in  1  limit-reached level from the comparator; low means count ≥ limit.
- CC_SPEEDCOUNTER_data_OutBUS  out  SPEEDCOUNTER_DATAWIDTH  current count; feeds the comparator data input.
- CC_SPEEDCOUNTER_tick_Out  out  1  one-cycle pulse per period.
- CC_SPEEDCOUNTER_tickCount_OutBUS  out  SPEEDCOUNTER_TICKWIDTH  number of ticks since start.
- CC_SPEEDCOUNTER_running_Out  out  1  high while in RUN.
- CC_SPEEDCOUNTER_timeout_Out  out  1  sticky watchdog flag (see Configuration).

## Operation
- FSM states are IDLE, RUN and PAUSE. Reset enters IDLE.
- IDLE:
  - Count is held at 0.
  - start low → RUN.
  - pause and clear are ignored.
- RUN:
  - Each cycle the count goes to count+1.
  - If clear is low, the count goes to 0 and tick pulses instead of incrementing.
  - pause low with start high → PAUSE, and the count holds.
- PAUSE:
  - Count, tickCount and tick are held; tick is 0.
  - clear is ignored.
  - pause high → RUN.
- start low in any state:
  - count goes to 0 and tickCount goes to 0.
  - The next state is RUN.
  - No tick is produced.
- Priority: reset > start > clear > pause > increment.
- When clear and pause are low together in RUN, the clear and tick take effect first and the FSM still enters PAUSE.
- tickCount increments on each tick and wraps modulo 2^TICKWIDTH.
- Count arithmetic is unsigned. With watchdog compiled out, the count saturates at all-ones (2^W−1) and does not wrap.
- All outputs are registered.

## Timing
- Reset (asynchronous, immediate):
  - count 0, tick 0, tickCount 0.
  - running 0, timeout 0.
  - state IDLE.
- Start latency: start sampled low at edge k → running=1 after edge k. The first increment to 1 is at edge k+1.
- Loop with the comparator:
  - The count reaches L at edge n.
  - The comparator drives clear low combinationally during that cycle.
  - At edge n+1 the count becomes 0 and tick is 1 for that one cycle.
  - Period = L+1 cycles.
- Limit 0: clear stays low, the count stays 0, and tick is high every cycle in RUN.
- Limit changed mid-count below the current count: clear goes low immediately, and the restart happens on the next edge.
- Reset asserted mid-period: the counter aborts with no tick and returns to IDLE.

## Configuration
- CC_SPEEDCOUNTER_WATCHDOG_EN defined:
  - In RUN, a count equal to all-ones with clear still high forces the count to 0 on the next edge.
  - It also sets timeout to 1 and produces no tick.
  - timeout stays 1 until reset or start.
- Not defined:
  - The count saturates at all-ones.
  - timeout is tied 0.

## Test plan
- Reset then start low for 1 cycle, limit 5 via the comparator model → running=1; data 0,1,2,3,4,5,0; tick high exactly when data returns to 0; period 6 cycles; tickCount 1,2,3….
- Limit 0 in RUN → data stays 0; tick high every cycle; tickCount increments each cycle and wraps 255→0 with TICKWIDTH=8.
- Pause low at data=3 for 4 cycles, then high → data holds at 3 with no tick; counting resumes 4,5,0.
- Start low at data=4, tickCount=7 → next edge data=0, tickCount=0, no tick, running=1.
- DATAWIDTH=4, clear held high:
  - Without WATCHDOG_EN → data saturates at 15, timeout=0.
  - With WATCHDOG_EN → 15→0 and timeout=1 sticky until start.
- Reset asserted asynchronously mid-count at data=9 → all outputs 0 immediately, before any clock edge; state IDLE; start is required to resume.
